// File: rtl/decode_sequencer.sv
// ---------------------------------------------------------------------------
// decode_sequencer
//
// Decode-stage sequencer between instruction fetch and execute. Fetched
// instructions land in a two-entry skid buffer (slot A drives the outputs,
// slot B absorbs one extra beat so that finstReady can be computed from
// registered state only). Each instruction is classified at enqueue into the
// 3-bit immediate-type code and an illegal-opcode flag. A flush empties the
// buffer and drops the incoming fetch beat. A saturating counter records
// every cycle in which execute back-pressures a valid instruction.
//
// Ports:
//   clk         core clock, all state updates on the rising edge
//   rstN        synchronous active-low reset
//   finstValid  fetch presents an instruction
//   finst       fetched instruction word
//   finstPc     PC of finst
//   finstReady  sequencer accepts finst this cycle
//   flush       discard all buffered and incoming instructions
//   dinstValid  decode output holds a valid instruction
//   dinst       instruction word ([31:7] feeds the immediate decoder)
//   dinstPc     PC of dinst
//   immType     000 I, 001 S, 010 B, 011 U, 100 J, 111 none
//   illegal     dinst has an unrecognised opcode
//   dinstReady  execute accepts dinst this cycle
//   stallCount  saturating count of cycles with dinstValid & !dinstReady
// ---------------------------------------------------------------------------
module decode_sequencer #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   finstValid,
    input  logic [31:0]            finst,
    input  logic [63:0]            finstPc,
    output logic                   finstReady,
    input  logic                   flush,
    output logic                   dinstValid,
    output logic [31:0]            dinst,
    output logic [63:0]            dinstPc,
    output logic [2:0]             immType,
    output logic                   illegal,
    input  logic                   dinstReady,
    output logic [STALL_CNT_W-1:0] stallCount
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

    // Opcode classifier: returns {illegal, immType}. Any opcode with
    // bits [1:0] != 2'b11 lands in the default arm and is flagged illegal.
    function automatic logic [3:0] classify(input logic [6:0] opcode);
        logic [3:0] res;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b0011011,
            7'b1100111, 7'b1110011:              res = {1'b0, IMM_I};
            7'b0100011:                          res = {1'b0, IMM_S};
            7'b1100011:                          res = {1'b0, IMM_B};
            7'b0110111, 7'b0010111:              res = {1'b0, IMM_U};
            7'b1101111:                          res = {1'b0, IMM_J};
            7'b0110011, 7'b0111011, 7'b0001111:  res = {1'b0, IMM_NONE};
            default:                             res = {1'b1, IMM_NONE};
        endcase
        return res;
    endfunction

    // State and slot storage
    state_e                 state_q, state_d;
    logic [31:0]            a_inst_q, a_inst_d;
    logic [63:0]            a_pc_q, a_pc_d;
    logic [2:0]             a_imm_q, a_imm_d;
    logic                   a_ill_q, a_ill_d;
    logic [31:0]            b_inst_q, b_inst_d;
    logic [63:0]            b_pc_q, b_pc_d;
    logic [2:0]             b_imm_q, b_imm_d;
    logic                   b_ill_q, b_ill_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    // Handshake and slot-load controls
    logic       enq_s;
    logic       deq_s;
    logic       load_a_new_s;
    logic       load_a_from_b_s;
    logic       load_b_s;
    logic [3:0] class_s;

    assign enq_s   = finstValid & finstReady & ~flush;
    assign deq_s   = dinstValid & dinstReady;
    assign class_s = classify(finst[6:0]);

    // Output comb: handshake outputs depend only on registered state and rstN
    always_comb begin
        finstReady = 1'b0;
        dinstValid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                finstReady = rstN;
                dinstValid = 1'b0;
            end
            ST_ONE: begin
                finstReady = rstN;
                dinstValid = 1'b1;
            end
            ST_TWO: begin
                finstReady = 1'b0;
                dinstValid = 1'b1;
            end
            default: begin
                finstReady = 1'b0;
                dinstValid = 1'b0;
            end
        endcase
    end

    // Next-state comb: occupancy transitions and which slot gets loaded
    always_comb begin
        state_d         = state_q;
        load_a_new_s    = 1'b0;
        load_a_from_b_s = 1'b0;
        load_b_s        = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (enq_s) begin
                    load_a_new_s = 1'b1;
                    state_d      = ST_ONE;
                end else begin
                    state_d      = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (enq_s && deq_s) begin
                    load_a_new_s = 1'b1;
                    state_d      = ST_ONE;
                end else if (enq_s) begin
                    load_b_s     = 1'b1;
                    state_d      = ST_TWO;
                end else if (deq_s) begin
                    state_d      = ST_EMPTY;
                end else begin
                    state_d      = ST_ONE;
                end
            end
            ST_TWO: begin
                // finstReady is low here, so only a dequeue can move us
                if (deq_s) begin
                    load_a_from_b_s = 1'b1;
                    state_d         = ST_ONE;
                end else begin
                    state_d         = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush wins over every transition; slot contents become don't-care
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_d;
        end
    end

    // Slot datapath comb: load slot A from fetch or from slot B, slot B from fetch
    always_comb begin
        a_inst_d = a_inst_q;
        a_pc_d   = a_pc_q;
        a_imm_d  = a_imm_q;
        a_ill_d  = a_ill_q;
        b_inst_d = b_inst_q;
        b_pc_d   = b_pc_q;
        b_imm_d  = b_imm_q;
        b_ill_d  = b_ill_q;
        if (load_a_new_s) begin
            a_inst_d = finst;
            a_pc_d   = finstPc;
            a_imm_d  = class_s[2:0];
            a_ill_d  = class_s[3];
        end else if (load_a_from_b_s) begin
            a_inst_d = b_inst_q;
            a_pc_d   = b_pc_q;
            a_imm_d  = b_imm_q;
            a_ill_d  = b_ill_q;
        end else begin
            a_inst_d = a_inst_q;
            a_pc_d   = a_pc_q;
            a_imm_d  = a_imm_q;
            a_ill_d  = a_ill_q;
        end
        if (load_b_s) begin
            b_inst_d = finst;
            b_pc_d   = finstPc;
            b_imm_d  = class_s[2:0];
            b_ill_d  = class_s[3];
        end else begin
            b_inst_d = b_inst_q;
            b_pc_d   = b_pc_q;
            b_imm_d  = b_imm_q;
            b_ill_d  = b_ill_q;
        end
    end

    // Stall counter comb: count back-pressured cycles, hold at all-ones
    always_comb begin
        stall_count_d = stall_count_q;
        if (dinstValid && !dinstReady && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + STALL_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State register: synchronous active-low reset, flush does not touch the counter
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q       <= ST_EMPTY;
            a_inst_q      <= 32'h0000_0000;
            a_pc_q        <= 64'h0000_0000_0000_0000;
            a_imm_q       <= IMM_NONE;
            a_ill_q       <= 1'b0;
            b_inst_q      <= 32'h0000_0000;
            b_pc_q        <= 64'h0000_0000_0000_0000;
            b_imm_q       <= IMM_NONE;
            b_ill_q       <= 1'b0;
            stall_count_q <= {STALL_CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            a_inst_q      <= a_inst_d;
            a_pc_q        <= a_pc_d;
            a_imm_q       <= a_imm_d;
            a_ill_q       <= a_ill_d;
            b_inst_q      <= b_inst_d;
            b_pc_q        <= b_pc_d;
            b_imm_q       <= b_imm_d;
            b_ill_q       <= b_ill_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Decode outputs come straight from slot A flops
    assign dinst      = a_inst_q;
    assign dinstPc    = a_pc_q;
    assign immType    = a_imm_q;
    assign illegal    = a_ill_q;
    assign stallCount = stall_count_q;

endmodule
